slave_in_port: RTL and testbench

Slave-side receive port of the serial bus. Deserialises the bit-serial address, burst length and write data sent by the master output port. Issues word-wide write strobes and read requests to the slave core, and provides `s_ready` flow control back to the master. One instance sits between the bus and each slave core; a future slave output port serves the returned read data.

---
 rtl/serial_bus_pkg.sv | 23 ++
 rtl/slave_in_port_if.sv | 45 ++++
 rtl/serial_deser.sv | 47 ++++
 rtl/slave_in_port.sv | 172 +++++++++++++++++
 tb/tb_slave_in_port.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared types and constants for the serial bus ports.
// Holds the receive-port state encoding and the bus instruction codes.
package serial_bus_pkg;

    localparam int unsigned DEF_ADDR_SIZE  = 12;
    localparam int unsigned DEF_WORD_SIZE  = 8;
    localparam int unsigned DEF_BURST_SIZE = 15;

    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_B_READ  = 3'd3;
    localparam logic [2:0] S_B_WRITE = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_RX,
        BURST_RX,
        DATA_RX,
        READ_REQ,
        READ_HOLD
    } state_t;

endpackage

// File: rtl/slave_in_port_if.sv
// slave_in_port_if: serial bus inputs, flow control and core-side outputs.
// master drives the serial bus and core_ready, slave is the receive port.
interface slave_in_port_if #(
    parameter int unsigned SLAVE_ADDR_SIZE = 12,
    parameter int unsigned WORD_SIZE       = 8,
    parameter int unsigned BURST_SIZE      = 15
);
    logic                       slave_sel;
    logic                       addr_bus;
    logic                       w_data_bus;
    logic                       burst_size_bus;
    logic                       addr_done;
    logic                       read_en;
    logic                       m_b_tx_valid;
    logic                       burst_done;
    logic                       tx_done;
    logic                       split_on;
    logic                       core_ready;
    logic                       s_ready;
    logic                       wr_strobe;
    logic [SLAVE_ADDR_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0]       wr_data;
    logic                       rd_req;
    logic [SLAVE_ADDR_SIZE-1:0] rd_addr;
    logic [BURST_SIZE-1:0]      rd_len;
    logic                       busy;
    logic                       proto_err;

    modport master (
        output slave_sel, addr_bus, w_data_bus, burst_size_bus,
        output addr_done, read_en, m_b_tx_valid, burst_done,
        output tx_done, split_on, core_ready,
        input  s_ready, wr_strobe, wr_addr, wr_data,
        input  rd_req, rd_addr, rd_len, busy, proto_err
    );

    modport slave (
        input  slave_sel, addr_bus, w_data_bus, burst_size_bus,
        input  addr_done, read_en, m_b_tx_valid, burst_done,
        input  tx_done, split_on, core_ready,
        output s_ready, wr_strobe, wr_addr, wr_data,
        output rd_req, rd_addr, rd_len, busy, proto_err
    );

endinterface

// File: rtl/serial_deser.sv
// serial_deser: LSB-first shift-in register with a bit counter.
// full_o flags the bit completing the word; word_o already includes it.
module serial_deser #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         valid_i,
    input  logic         bit_i,
    output logic         full_o,
    output logic [W-1:0] word_o
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;

    always_comb begin
        word_o = sh_q;
        for (int i = 0; i < W; i++) begin
            if (cnt_q == CW'(i)) word_o[i] = bit_i;
        end
        full_o = valid_i && (cnt_q == CW'(W - 1));
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (valid_i) begin
            sh_d  = word_o;
            // wrap so back-to-back words need no explicit clear
            cnt_d = full_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/slave_in_port.sv
// slave_in_port: slave-side receive port of the serial bus.
// Deserialises address, burst length and write data into core strobes/requests.
module slave_in_port #(
    parameter int unsigned SLAVE_ADDR_SIZE = 12,
    parameter int unsigned WORD_SIZE       = 8,
    parameter int unsigned BURST_SIZE      = 15
) (
    input logic            clk,
    input logic            rst,
    slave_in_port_if.slave bus
);
    import serial_bus_pkg::*;

    state_t                     state_q, state_d;
    logic                       rdy_q;
    logic                       s_ready_w;
    logic [SLAVE_ADDR_SIZE-1:0] base_q, base_d;
    logic [SLAVE_ADDR_SIZE-1:0] wcnt_q, wcnt_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [SLAVE_ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_SIZE-1:0]       wr_data_q, wr_data_d;
    logic                       rd_req_q, rd_req_d;
    logic [SLAVE_ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [BURST_SIZE-1:0]      rd_len_q, rd_len_d;
    logic                       perr_q, perr_d;

    logic                       clr;
    logic                       a_valid, b_valid, d_valid;
    logic                       a_full, b_full, d_full;
    logic [SLAVE_ADDR_SIZE-1:0] a_word;
    logic [BURST_SIZE-1:0]      b_word;
    logic [WORD_SIZE-1:0]       d_word;

    assign clr     = (state_q == IDLE);
    assign a_valid = (state_q == ADDR_RX) && rdy_q;
    assign b_valid = (state_q == BURST_RX);
    assign d_valid = (state_q == DATA_RX) && rdy_q;

    assign s_ready_w = !rst && bus.core_ready &&
                       (state_q == IDLE || state_q == ADDR_RX ||
                        state_q == BURST_RX || state_q == DATA_RX);

    serial_deser #(.W(SLAVE_ADDR_SIZE)) u_addr (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clr),
        .valid_i (a_valid),
        .bit_i   (bus.addr_bus),
        .full_o  (a_full),
        .word_o  (a_word)
    );

    serial_deser #(.W(BURST_SIZE)) u_burst (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clr),
        .valid_i (b_valid),
        .bit_i   (bus.burst_size_bus),
        .full_o  (b_full),
        .word_o  (b_word)
    );

    serial_deser #(.W(WORD_SIZE)) u_data (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clr),
        .valid_i (d_valid),
        .bit_i   (bus.w_data_bus),
        .full_o  (d_full),
        .word_o  (d_word)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        wcnt_d      = wcnt_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_len_d    = rd_len_q;
        perr_d      = 1'b0;
        // abort wins over any completion in the same cycle
        if (state_q != IDLE && (bus.split_on || !bus.slave_sel)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    wcnt_d = '0;
                    if (bus.slave_sel) state_d = ADDR_RX;
                end
                ADDR_RX: begin
                    if (a_full) begin
                        base_d = a_word;
                        perr_d = !bus.addr_done;
                        if (bus.m_b_tx_valid) begin
                            state_d = BURST_RX;
                        end else if (bus.read_en) begin
                            state_d   = READ_REQ;
                            rd_req_d  = 1'b1;
                            rd_addr_d = a_word;
                            rd_len_d  = BURST_SIZE'(1);
                        end else begin
                            state_d = DATA_RX;
                        end
                    end
                end
                BURST_RX: begin
                    if (b_full) begin
                        state_d   = READ_REQ;
                        rd_addr_d = base_q;
                        rd_len_d  = b_word;
                        rd_req_d  = (b_word != '0);
                        perr_d    = !bus.burst_done || (b_word == '0);
                    end
                end
                DATA_RX: begin
                    if (d_full) begin
                        wr_strobe_d = 1'b1;
                        wr_data_d   = d_word;
                        wr_addr_d   = base_q + wcnt_q;
                        wcnt_d      = wcnt_q + SLAVE_ADDR_SIZE'(1);
                        if (bus.tx_done) state_d = IDLE;
                    end
                end
                READ_REQ:  state_d = READ_HOLD;
                READ_HOLD: state_d = READ_HOLD;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            base_q      <= '0;
            wcnt_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= s_ready_w;
            base_q      <= base_d;
            wcnt_q      <= wcnt_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            rd_len_q    <= rd_len_d;
            perr_q      <= perr_d;
        end
    end

    assign bus.s_ready   = s_ready_w;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_len    = rd_len_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_slave_in_port.sv
// tb_slave_in_port: randomized bus master with a scoreboard of expected
// write strobes, read requests and protocol-error pulses.
`timescale 1ns/1ps
module tb_slave_in_port;

    localparam int AW = 12;
    localparam int WW = 8;
    localparam int BW = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slave_in_port_if #(.SLAVE_ADDR_SIZE(AW), .WORD_SIZE(WW), .BURST_SIZE(BW)) sif ();

    slave_in_port #(.SLAVE_ADDR_SIZE(AW), .WORD_SIZE(WW), .BURST_SIZE(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    typedef struct {
        int kind;
        int a;
        int d;
        int cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lowcnt = 0;
    bit   meas = 1'b0;
    logic rdy_sh = 1'b0;
    int   wbuf[8];

    always @(posedge clk) cyc <= cyc + 1;

    // s_ready of the previous cycle, as the master sees it
    always @(negedge clk) begin
        #1;
        rdy_sh = sif.s_ready;
        if (meas && sif.s_ready !== 1'b1) lowcnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int a, input int d, input int c);
        ev_t e;
        e.kind = k; e.a = a; e.d = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input int a, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: kind %0d addr %0h data %0h at cycle %0d, expected none",
                     k, a, d, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("ev_kind", k, e.kind);
        chk("ev_addr", a, e.a);
        chk("ev_data", d, e.d);
        chk("ev_cycle", cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sif.proto_err === 1'b1) pop_cmp(2, 0, 0);
            if (sif.rd_req === 1'b1) pop_cmp(1, int'(sif.rd_addr), int'(sif.rd_len));
            if (sif.wr_strobe === 1'b1) pop_cmp(0, int'(sif.wr_addr), int'(sif.wr_data));
        end
    end

    task automatic clear_bus();
        sif.addr_bus = 1'b0; sif.w_data_bus = 1'b0; sif.burst_size_bus = 1'b0;
        sif.addr_done = 1'b0; sif.read_en = 1'b0; sif.m_b_tx_valid = 1'b0;
        sif.burst_done = 1'b0; sif.tx_done = 1'b0; sif.split_on = 1'b0;
    endtask

    // bus: 0 address, 1 burst length, 2 write data; mk = markers on the last bit
    task automatic shift(input logic [31:0] v, input int n, input int bus,
                         input logic [2:0] mk, input int stall_idx, output int lcyc);
        int   idx = 0;
        int   st = 0;
        int   guard = 0;
        bit   stalled = 1'b0;
        logic ok;
        lcyc = 0;
        while (idx < n) begin
            @(negedge clk);
            ok = (bus == 1) ? 1'b1 : rdy_sh;
            if (!stalled && idx == stall_idx) begin
                st = 4;
                stalled = 1'b1;
            end
            sif.core_ready = (st == 0);
            if (st > 0) st--;
            clear_bus();
            case (bus)
                0: sif.addr_bus = v[idx];
                1: sif.burst_size_bus = v[idx];
                default: sif.w_data_bus = v[idx];
            endcase
            if (idx == n - 1) begin
                case (bus)
                    0: {sif.m_b_tx_valid, sif.read_en, sif.addr_done} = mk;
                    1: sif.burst_done = mk[0];
                    default: sif.tx_done = mk[0];
                endcase
            end
            if (ok) begin
                lcyc = cyc;
                idx++;
            end
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL shift_timeout: bit %0d of %0d never accepted, expected acceptance", idx, n);
                idx = n;
            end
        end
    endtask

    task automatic begin_tx();
        @(negedge clk);
        clear_bus();
        sif.core_ready = 1'b1;
        sif.slave_sel = 1'b1;
    endtask

    task automatic end_tx();
        @(negedge clk);
        clear_bus();
        sif.core_ready = 1'b1;
        sif.slave_sel = 1'b0;
    endtask

    task automatic idle_check(input string nm);
        repeat (2) @(negedge clk);
        chk(nm, sif.busy, 1'b0);
    endtask

    task automatic do_write(input int addr, input int nw, input bit ad,
                            input int stall_word, input int stall_bit);
        int lc;
        begin_tx();
        shift(addr, AW, 0, {2'b00, ad}, -1, lc);
        if (!ad) push(2, 0, 0, lc + 1);
        for (int w = 0; w < nw; w++) begin
            shift(wbuf[w], WW, 2, {2'b00, (w == nw - 1)},
                  (w == stall_word) ? stall_bit : -1, lc);
            push(0, (addr + w) % (1 << AW), wbuf[w], lc + 1);
        end
        end_tx();
    endtask

    task automatic do_read(input int addr, input bit burst, input int len,
                           input bit ad, input bit bd, input int hold);
        int lc;
        int bad = 0;
        begin_tx();
        shift(addr, AW, 0, {burst, !burst, ad}, -1, lc);
        if (!ad) push(2, 0, 0, lc + 1);
        if (!burst) begin
            push(1, addr, 1, lc + 1);
        end else begin
            shift(len, BW, 1, {2'b00, bd}, -1, lc);
            if (!bd || len == 0) push(2, 0, 0, lc + 1);
            if (len != 0) push(1, addr, len, lc + 1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            if (sif.s_ready !== 1'b0) bad++;
        end
        chk("read_hold_s_ready_low", bad, 0);
        end_tx();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_s_ready"}, sif.s_ready, 1'b0);
        chk({nm, "_wr_strobe"}, sif.wr_strobe, 1'b0);
        chk({nm, "_wr_addr"}, sif.wr_addr, 0);
        chk({nm, "_wr_data"}, sif.wr_data, 0);
        chk({nm, "_rd_req"}, sif.rd_req, 1'b0);
        chk({nm, "_rd_addr"}, sif.rd_addr, 0);
        chk({nm, "_rd_len"}, sif.rd_len, 0);
        chk({nm, "_busy"}, sif.busy, 1'b0);
        chk({nm, "_proto_err"}, sif.proto_err, 1'b0);
    endtask

    task automatic pulse_rst(input string nm);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero(nm);
        @(negedge clk);
        clear_bus();
        sif.slave_sel = 1'b0;
        sif.core_ready = 1'b1;
        rst = 1'b0;
        idle_check({nm, "_busy_after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        clear_bus();
        sif.slave_sel = 1'b0;
        sif.core_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_s_ready", sif.s_ready, 1'b1);

        wbuf[0] = 'h3B;
        do_write('hA5C, 1, 1'b1, -1, -1);
        idle_check("write_idle");

        wbuf[0] = 'h11; wbuf[1] = 'h22; wbuf[2] = 'h33;
        do_write('hFFF, 3, 1'b1, -1, -1);
        idle_check("burst_write_idle");

        do_read('h123, 1'b0, 1, 1'b1, 1'b1, 5);
        idle_check("read_idle");

        do_read('h040, 1'b1, 5, 1'b1, 1'b0, 4);
        idle_check("burst_read_idle");
        do_read('h7A1, 1'b1, 0, 1'b1, 1'b1, 3);
        idle_check("zero_len_idle");

        wbuf[0] = 'h96;
        lowcnt = 0;
        begin_tx();
        shift('h2C4, AW, 0, 3'b001, -1, lc);
        meas = 1'b1;
        shift('h96, WW, 2, 3'b001, 3, lc);
        meas = 1'b0;
        push(0, 'h2C4, 'h96, lc + 1);
        end_tx();
        chk("stall_s_ready_low_cycles", lowcnt, 4);
        idle_check("stall_idle");

        wbuf[0] = 'h5C;
        do_write('h0F0, 1, 1'b0, -1, -1);

        // split_on mid-address
        begin_tx();
        shift('h555, 5, 0, 3'b000, -1, lc);
        @(negedge clk);
        sif.split_on = 1'b1;
        end_tx();
        idle_check("split_addr_idle");

        // split_on mid-data
        begin_tx();
        shift('h321, AW, 0, 3'b001, -1, lc);
        shift('hFF, 3, 2, 3'b000, -1, lc);
        @(negedge clk);
        sif.split_on = 1'b1;
        end_tx();
        idle_check("split_data_idle");

        // split in the strobe cycle of a completed word: strobe still fires
        begin_tx();
        shift('h100, AW, 0, 3'b001, -1, lc);
        shift('h5A, WW, 2, 3'b000, -1, lc);
        push(0, 'h100, 'h5A, lc + 1);
        @(negedge clk);
        clear_bus();
        sif.split_on = 1'b1;
        end_tx();
        idle_check("split_after_word_idle");

        // slave_sel drop mid-data
        begin_tx();
        shift('h432, AW, 0, 3'b001, -1, lc);
        shift('hAA, 5, 2, 3'b000, -1, lc);
        end_tx();
        idle_check("desel_data_idle");

        // async reset mid-address and mid-data
        begin_tx();
        shift('h777, 6, 0, 3'b000, -1, lc);
        pulse_rst("rst_addr");
        begin_tx();
        shift('h888, AW, 0, 3'b001, -1, lc);
        shift('hC3, 5, 2, 3'b000, -1, lc);
        pulse_rst("rst_data");

        for (int t = 0; t < 24; t++) begin
            int k;
            int addr;
            k = $urandom_range(0, 2);
            addr = $urandom_range(0, (1 << AW) - 1);
            if (k == 0) begin
                int nw;
                nw = $urandom_range(1, 4);
                for (int w = 0; w < nw; w++) wbuf[w] = $urandom_range(0, 255);
                do_write(addr, nw, ($urandom_range(0, 7) != 0),
                         ($urandom_range(0, 1) == 1) ? $urandom_range(0, nw - 1) : -1,
                         $urandom_range(0, WW - 1));
            end else if (k == 1) begin
                do_read(addr, 1'b0, 1, ($urandom_range(0, 7) != 0), 1'b1,
                        $urandom_range(1, 4));
            end else begin
                do_read(addr, 1'b1, $urandom_range(1, (1 << BW) - 1),
                        1'b1, ($urandom_range(0, 3) != 0), $urandom_range(1, 4));
            end
            idle_check("rand_idle");
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
